// File: rtl/spi_sd_pkg.sv
// Shared constants for the SD SPI slave: register offsets, status bits, byte enables.
package spi_sd_pkg;
   localparam logic [3:0] ADDR_DATA      = 4'h0;
   localparam logic [3:0] ADDR_STAT      = 4'h4;
   localparam int         STAT_RX_VALID  = 0;
   localparam int         STAT_TX_FULL   = 1;
   localparam int         STAT_OVERRUN   = 2;
   localparam int         STAT_CS_ACTIVE = 3;
   localparam logic [3:0] BYTESEL_BYTE   = 4'b0001;
   localparam logic [3:0] BYTESEL_READ   = 4'b0000;
endpackage

// File: rtl/spi_sd_slave_if.sv
// Single-cycle-ack peripheral bus shared by the SD-path blocks.
interface spi_sd_slave_if;
   logic        cs;
   logic [31:0] bus_addr;
   logic [31:0] bus_wr_val;
   logic [3:0]  bus_bytesel;
   logic        bus_ack;
   logic [31:0] bus_data;

   modport master (output cs, bus_addr, bus_wr_val, bus_bytesel, input bus_ack, bus_data);
   modport slave  (input cs, bus_addr, bus_wr_val, bus_bytesel, output bus_ack, bus_data);
endinterface

// File: rtl/spi_sd_sync.sv
// N-flop synchroniser plus one history flop producing single-cycle rise/fall pulses.
module spi_sd_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   // chain_q[STAGES-1] is the synchronised value, chain_q[STAGES] its previous cycle
   logic [STAGES:0] chain_q, chain_d;

   // shift the async input one stage deeper each clock
   always_comb chain_d = {chain_q[STAGES-1:0], d};

   // synchroniser and history register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain_q <= {(STAGES+1){RST_VAL}};
      else        chain_q <= chain_d;
   end

   assign q    = chain_q[STAGES-1];
   assign rise = chain_q[STAGES-1] & ~chain_q[STAGES];
   assign fall = ~chain_q[STAGES-1] & chain_q[STAGES];
endmodule

// File: rtl/spi_sd_slave.sv
// SPI mode-0 card-side slave: bus register decode plus a byte engine driven by
// synchronised SCLK/CS_N/MOSI edges in the system clock domain.
module spi_sd_slave
   import spi_sd_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
   input  logic             clk,
   input  logic             rst_n,
   spi_sd_slave_if.slave    bus,
   input  logic             spi_sclk,
   input  logic             spi_cs_n,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic             spi_miso_oe
);
   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_n_s, cs_end, cs_start;
   logic mosi_s, mosi_rise, mosi_fall;

   spi_sd_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .d(spi_sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
   spi_sd_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
      .clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_n_s), .rise(cs_end), .fall(cs_start));
   spi_sd_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

   // Bits the block intentionally ignores
   logic unused_bits;
   assign unused_bits = ^{sclk_s, mosi_rise, mosi_fall, bus.bus_addr[31:4], bus.bus_wr_val[31:8]};

   logic       ack_q, ack_d;
   logic [31:0] rdata_q, rdata_d;
   logic [7:0] rx_byte_q, rx_byte_d, tx_hold_q, tx_hold_d;
   logic [7:0] shift_rx_q, shift_rx_d, shift_tx_q, shift_tx_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       rx_valid_q, rx_valid_d, tx_full_q, tx_full_d, overrun_q, overrun_d;
   logic       miso_q, miso_d, oe_q, oe_d;

   logic       cs_active, accept, rd, wr;
   logic [3:0] addr;
   logic [7:0] reload_byte;
   logic [7:0] rx_next;

   assign cs_active   = ~cs_n_s;
   assign accept      = bus.cs & ~ack_q;
   assign rd          = accept && (bus.bus_bytesel == BYTESEL_READ);
   assign wr          = accept && (bus.bus_bytesel == BYTESEL_BYTE);
   assign addr        = bus.bus_addr[3:0];
   assign reload_byte = tx_full_q ? tx_hold_q : IDLE_BYTE;
   assign rx_next     = {shift_rx_q[6:0], mosi_s};

   // Next state: bus reads/overrun clear, then byte engine, then TX write so
   // that byte completion beats an rx read and a TX write beats a reload.
   always_comb begin
      ack_d      = accept;
      rdata_d    = '0;
      rx_byte_d  = rx_byte_q;
      tx_hold_d  = tx_hold_q;
      shift_rx_d = shift_rx_q;
      shift_tx_d = shift_tx_q;
      bit_cnt_d  = bit_cnt_q;
      rx_valid_d = rx_valid_q;
      tx_full_d  = tx_full_q;
      overrun_d  = overrun_q;
      miso_d     = miso_q;
      oe_d       = oe_q;

      if (rd) begin
         case (addr)
            ADDR_DATA: begin
               rdata_d    = {24'b0, rx_byte_q};
               rx_valid_d = 1'b0;
            end
            ADDR_STAT: begin
               rdata_d[STAT_RX_VALID]  = rx_valid_q;
               rdata_d[STAT_TX_FULL]   = tx_full_q;
               rdata_d[STAT_OVERRUN]   = overrun_q;
               rdata_d[STAT_CS_ACTIVE] = cs_active;
            end
            default: rdata_d = '0;
         endcase
      end
      if (wr && addr == ADDR_STAT && bus.bus_wr_val[STAT_OVERRUN]) overrun_d = 1'b0;

      if (cs_start) begin
         bit_cnt_d  = '0;
         shift_tx_d = reload_byte;
         tx_full_d  = 1'b0;
         miso_d     = reload_byte[7];
         oe_d       = 1'b1;
      end else if (cs_end) begin
         bit_cnt_d = '0;
         miso_d    = 1'b1;
         oe_d      = 1'b0;
      end else if (cs_active) begin
         if (sclk_rise) begin
            shift_rx_d = rx_next;
            if (bit_cnt_q == 3'd7) begin
               bit_cnt_d  = '0;
               rx_byte_d  = rx_next;
               if (rx_valid_q && !(rd && addr == ADDR_DATA)) overrun_d = 1'b1;
               rx_valid_d = 1'b1;
               shift_tx_d = reload_byte;
               tx_full_d  = 1'b0;
            end else begin
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end else if (sclk_fall) begin
            // bit_cnt 0 here means a freshly reloaded byte: present its MSB
            if (bit_cnt_q == 3'd0) begin
               miso_d = shift_tx_q[7];
            end else begin
               miso_d     = shift_tx_q[6];
               shift_tx_d = {shift_tx_q[6:0], 1'b1};
            end
         end
      end

      if (wr && addr == ADDR_DATA) begin
         tx_hold_d = bus.bus_wr_val[7:0];
         tx_full_d = 1'b1;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q      <= 1'b0;
         rdata_q    <= '0;
         rx_byte_q  <= '0;
         tx_hold_q  <= '0;
         shift_rx_q <= IDLE_BYTE;
         shift_tx_q <= IDLE_BYTE;
         bit_cnt_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_full_q  <= 1'b0;
         overrun_q  <= 1'b0;
         miso_q     <= 1'b1;
         oe_q       <= 1'b0;
      end else begin
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
         rx_byte_q  <= rx_byte_d;
         tx_hold_q  <= tx_hold_d;
         shift_rx_q <= shift_rx_d;
         shift_tx_q <= shift_tx_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_valid_q <= rx_valid_d;
         tx_full_q  <= tx_full_d;
         overrun_q  <= overrun_d;
         miso_q     <= miso_d;
         oe_q       <= oe_d;
      end
   end

   assign bus.bus_ack  = ack_q;
   assign bus.bus_data = rdata_q;
   assign spi_miso     = miso_q;
   assign spi_miso_oe  = oe_q;
endmodule

// File: tb/tb_spi_sd_slave.sv
// Directed + randomized bench for spi_sd_slave with a register-level reference model.
module tb_spi_sd_slave;
   import spi_sd_pkg::*;

   localparam int HALF = 60;  // SCLK half period in ns (clk = 10 ns)

   logic clk = 1'b0, rst_n = 1'b0;
   logic sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
   logic miso, miso_oe;

   always #5 clk = ~clk;

   spi_sd_slave_if bus_if();

   spi_sd_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus_if.slave),
      .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
      .spi_miso(miso), .spi_miso_oe(miso_oe));

   int checks = 0, failures = 0;

   // Reference model of the programmer-visible state
   logic [7:0] m_rx_byte = 8'h00, m_tx_hold = 8'h00, m_cur = 8'hFF;
   bit m_rx_valid = 0, m_tx_full = 0, m_overrun = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_status(input bit cs_act);
      return {28'b0, cs_act, m_overrun, m_tx_full, m_rx_valid};
   endfunction

   function automatic void m_reset();
      m_rx_byte = 8'h00; m_tx_hold = 8'h00; m_cur = 8'hFF;
      m_rx_valid = 0; m_tx_full = 0; m_overrun = 0;
   endfunction

   // next MISO byte: pending TX byte if any, else idle pattern
   function automatic void m_take_tx();
      m_cur = m_tx_full ? m_tx_hold : 8'hFF;
      m_tx_full = 0;
   endfunction

   function automatic void m_byte_done(input logic [7:0] b);
      if (m_rx_valid) m_overrun = 1;
      m_rx_byte  = b;
      m_rx_valid = 1;
      m_take_tx();
   endfunction

   task automatic bus_access(input logic [3:0] a, input logic [3:0] bsel,
                             input logic [31:0] wv, output logic [31:0] rdv);
      @(posedge clk); #1;
      bus_if.cs = 1'b1; bus_if.bus_addr = {28'h0, a};
      bus_if.bus_bytesel = bsel; bus_if.bus_wr_val = wv;
      @(posedge clk); #1;
      bus_if.cs = 1'b0; bus_if.bus_bytesel = 4'b0000;
      rdv = bus_if.bus_data;
      @(posedge clk); #1;
   endtask

   task automatic bus_rd(input logic [3:0] a, output logic [31:0] rdv);
      bus_access(a, BYTESEL_READ, 32'h0, rdv);
   endtask

   task automatic bus_wr(input logic [3:0] a, input logic [31:0] wv);
      logic [31:0] dummy;
      bus_access(a, BYTESEL_BYTE, wv, dummy);
   endtask

   task automatic rd_status(input string tag, input bit cs_act);
      logic [31:0] v;
      bus_rd(ADDR_STAT, v);
      chk(tag, v, m_status(cs_act));
   endtask

   task automatic rd_data(input string tag);
      logic [31:0] v;
      bus_rd(ADDR_DATA, v);
      chk(tag, v, {24'b0, m_rx_byte});
      m_rx_valid = 0;
   endtask

   task automatic wr_tx(input logic [7:0] v);
      bus_wr(ADDR_DATA, {24'h0, v});
      m_tx_hold = v; m_tx_full = 1;
   endtask

   task automatic frame_begin();
      cs_n = 1'b0;
      m_take_tx();
      #(4*HALF);
   endtask

   task automatic frame_end();
      #(HALF);
      cs_n = 1'b1;
      #(4*HALF);
   endtask

   // host side of mode 0: drive MOSI while SCLK low, sample MISO on rising edge
   task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = tx[i];
         #(HALF);
         sclk = 1'b1;
         rx[i] = miso;
         #(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic spi_byte(input string tag, input logic [7:0] tx);
      logic [7:0] rx;
      spi_bits(tx, 8, rx);
      chk(tag, {24'b0, rx}, {24'b0, m_cur});
      m_byte_done(tx);
   endtask

   initial begin
      logic [31:0] v;
      logic [7:0]  b, rx;
      bus_if.cs = 1'b0; bus_if.bus_addr = '0; bus_if.bus_wr_val = '0; bus_if.bus_bytesel = '0;

      // reset values
      #23;
      chk("rst_ack", bus_if.bus_ack, 1'b0);
      chk("rst_data", bus_if.bus_data, 32'h0);
      chk("rst_miso", miso, 1'b1);
      chk("rst_oe", miso_oe, 1'b0);
      rst_n = 1'b1;
      rd_status("rst_status", 0);

      // reset in the middle of a frame
      wr_tx(8'($urandom));
      frame_begin();
      chk("oe_in_frame", miso_oe, 1'b1);
      spi_bits(8'($urandom), 4, rx);
      rst_n = 1'b0;
      #1;
      chk("midrst_miso", miso, 1'b1);
      chk("midrst_oe", miso_oe, 1'b0);
      chk("midrst_ack", bus_if.bus_ack, 1'b0);
      cs_n = 1'b1; mosi = 1'b0;
      #(4*HALF);
      rst_n = 1'b1;
      m_reset();
      rd_status("midrst_status", 0);
      b = 8'($urandom);
      frame_begin();
      spi_byte("midrst_new_miso", b);
      frame_end();
      rd_status("midrst_new_status", 0);
      rd_data("midrst_new_data");

      // 0x40 with no TX byte pending
      frame_begin();
      spi_byte("x40_miso", 8'h40);
      rd_status("x40_status_9", 1);
      rd_data("x40_data");
      rd_status("x40_status_8", 1);
      frame_end();

      // preloaded TX byte 0xA5
      wr_tx(8'hA5);
      rd_status("a5_txfull", 0);
      frame_begin();
      spi_byte("a5_miso", 8'($urandom));
      frame_end();
      rd_status("a5_txempty", 0);
      rd_data("a5_data");

      // overrun: two bytes without a read
      frame_begin();
      spi_byte("ovr_miso0", 8'h12);
      spi_byte("ovr_miso1", 8'h34);
      rd_status("ovr_status", 1);
      frame_end();
      rd_data("ovr_data");
      bus_wr(ADDR_STAT, 32'h4);
      m_overrun = 0;
      rd_status("ovr_cleared", 0);

      // partial byte then deselect
      frame_begin();
      spi_bits(8'($urandom), 5, rx);
      frame_end();
      chk("part_miso", miso, 1'b1);
      chk("part_oe", miso_oe, 1'b0);
      rd_status("part_status", 0);

      // cs held for 4 cycles: ack alternates, data only in ack cycles
      wr_tx(8'($urandom));
      @(posedge clk); #1;
      bus_if.cs = 1'b1; bus_if.bus_addr = 32'h4; bus_if.bus_bytesel = BYTESEL_READ;
      chk("hold_ack_pre", bus_if.bus_ack, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("hold_ack", bus_if.bus_ack, (k % 2 == 0) ? 1'b1 : 1'b0);
         chk("hold_data", bus_if.bus_data, (k % 2 == 0) ? m_status(0) : 32'h0);
      end
      bus_if.cs = 1'b0;
      @(posedge clk); #1;
      bus_rd(4'h8, v);
      chk("unmapped_rd", v, 32'h0);
      bus_wr(4'h8, 32'hFFFF_FFFF);
      rd_status("unmapped_wr", 0);

      // randomized frames against the model
      for (int it = 0; it < 8; it++) begin
         int nwr, nby;
         nwr = $urandom_range(0, 2);
         nby = $urandom_range(1, 3);
         for (int w = 0; w < nwr; w++) wr_tx(8'($urandom));
         frame_begin();
         for (int k = 0; k < nby; k++) spi_byte("rnd_miso", 8'($urandom));
         frame_end();
         rd_status("rnd_status", 0);
         if ($urandom_range(0, 1) == 1) rd_data("rnd_data");
         if ($urandom_range(0, 1) == 1) begin
            bus_wr(ADDR_STAT, 32'h4);
            m_overrun = 0;
         end
      end
      rd_data("final_data");
      rd_status("final_status", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
